neuron_operand_loader: RTL and testbench
========================================

# neuron_operand_loader

Upstream feeder and result capture for `neuron_unit`. Accepts a serial stream of 16-bit words over a valid/ready handshake and assembles them into one operand frame: four inputs, four weights, one signed bias. It holds the frame stable on the `neuron_unit` operand ports for a fixed settle window, then captures the neuron's `sum`/`out` into a result register presented over a second valid/ready handshake.

## Interface
- `DATA_W`, 16, operand word width (x, w, bias)
- `RES_W`, 32, width of `sum`/`out` from the neuron
- `SETTLE_CYCLES`, 6, cycles operands are held before capture; legal range 1..255

- `clock`  in  1  single clock; all state updates on rising edge
- `reset`  in  1  synchronous, active-high
- `flush`  in  1  synchronous abort of a partial frame
- `s_data`  in  DATA_W  stream word
- `s_valid`  in  1  stream word valid
- `s_ready`  out  1  loader can accept a word
- `x0`..`x3`  out  DATA_W each  operand inputs to neuron_unit
- `w0`..`w3`  out  DATA_W each  operand weights to neuron_unit
- `bias`  out  DATA_W  signed bias to neuron_unit
- `nu_sum`  in  RES_W  neuron_unit `sum`
- `nu_out`  in  RES_W  neuron_unit `out`
- `m_sum`  out  RES_W  captured sum
- `m_out`  out  RES_W  captured output
- `m_valid`  out  1  result valid
- `m_ready`  in  1  downstream accepts result
- `busy`  out  1  high in SETTLE or PRESENT
- `frame_cnt`  out  16  completed result transfers, modulo 2^16

## Operation
- Word order per frame, index 0..8: x0, w0, x1, w1, x2, w2, x3, w3, bias.
- States:
  - LOAD: `s_ready`=1. On `s_valid && s_ready`, write `s_data` into the register selected by the index, then increment the index. Accepting index 8 (bias) loads the settle counter with SETTLE_CYCLES-1 and moves to SETTLE. Index resets to 0.
  - SETTLE: `s_ready`=0 and operands frozen. The counter decrements each cycle. On the cycle it reads 0, capture `nu_sum`→`m_sum` and `nu_out`→`m_out`, set `m_valid`, and move to PRESENT.
  - PRESENT: `m_valid`=1, with `m_sum`/`m_out` stable. On `m_valid && m_ready`: clear `m_valid`, increment `frame_cnt`, and move to LOAD.
- Operand registers change only on accepted words. A partial frame leaves untouched registers at their previous values.
- `flush`:
  - In LOAD, resets the index to 0 and keeps operand values.
  - In SETTLE or PRESENT, it is ignored.
  - Flush together with an accepted word in the same cycle: flush wins and the word is dropped. `s_ready` stays 1, so upstream sees it consumed.
- `busy` = state != LOAD.
- `frame_cnt` wraps from 0xFFFF to 0x0000 with no flag.
- No arithmetic in this block. `bias` is passed bit-exact; sign interpretation belongs to neuron_unit.

## Timing
- Reset values:
  - All operands, `m_sum`, `m_out`, `m_valid`, `frame_cnt`: 0.
  - State LOAD, index 0.
  - `s_ready`=0 while `reset` is high, and 1 in the first cycle after it deasserts.
- An accepted word is visible on its operand port in the cycle after the accepting edge.
- Bias accepted at edge T: capture happens at edge T+SETTLE_CYCLES, and `m_valid` is high from that edge on.
- Result accepted at edge R: state is LOAD and `s_ready`=1 from R on. Minimum frame period is 9 + SETTLE_CYCLES + 1 cycles.
- `m_ready` may be high before `m_valid`. The transfer then occurs at the first edge with `m_valid`=1, so PRESENT lasts 1 cycle.
- Reset mid-frame or mid-SETTLE/PRESENT:
  - Everything returns to reset values at that edge.
  - A pending result is discarded without incrementing `frame_cnt`.
- `s_ready` and `busy` are decoded from registered state only. There is no combinational path from `m_ready` or `s_valid` to any output.

## Structure
- Shared package `neuron_pkg` holds:
  - state encoding `LOAD`/`SETTLE`/`PRESENT`
  - `WORDS_PER_FRAME`=9
  - word index constants `IDX_X0`..`IDX_BIAS`
  - default `DATA_W`/`RES_W`
- One natural sub-module, `settle_timer`: a loadable down-counter with a `done` output, 8-bit.
- `neuron_unit` is instantiated beside this block at the next level up, not inside it.

## Test plan
Bench uses a behavioural neuron: sum = Σx·w + sign-extended bias, out = max(sum, 0), with SETTLE_CYCLES=6.
- Basic frame: x=1,2,3,4, w=2,3,4,5, bias=50, streamed back-to-back, `m_ready`=1 → `m_sum`=90, `m_out`=90, `m_valid` 6 edges after bias accept, `frame_cnt`=1.
- Negative bias: same frame with bias=16'hFFCE (−50) → `m_sum`=32'hFFFFFFF6, `m_out`=0, and `bias` port reads 16'hFFCE.
- Backpressure:
  - Hold `m_ready`=0 for 20 cycles → `m_valid`, `m_sum`, `m_out` stable and `s_ready`=0 throughout.
  - Raise `m_ready` → one transfer, `s_ready`=1 next cycle.
- Flush: send 5 words, then flush, then a full new frame x=0,0,0,1 w=0,0,0,7 bias=0 → `m_sum`=7. Flush coincident with the 5th word drops that word.
- Reset in SETTLE: assert reset 3 cycles after bias accept → no `m_valid`, `frame_cnt`=0, all operands 0, `s_ready`=1 after release.
- Wrap: preload via 65536 minimal frames, or force the counter to 0xFFFF, then complete one frame → `frame_cnt`=0.

Source files
------------

// File: rtl/neuron_pkg.sv
// neuron_pkg: shared state encoding, frame layout and default widths for the neuron operand path
package neuron_pkg;
    localparam int DEF_DATA_W = 16;
    localparam int DEF_RES_W = 32;
    localparam int WORDS_PER_FRAME = 9;
    typedef enum logic [1:0] {LOAD, SETTLE, PRESENT} state_t;
    localparam logic [3:0] IDX_X0 = 4'd0;
    localparam logic [3:0] IDX_W0 = 4'd1;
    localparam logic [3:0] IDX_X1 = 4'd2;
    localparam logic [3:0] IDX_W1 = 4'd3;
    localparam logic [3:0] IDX_X2 = 4'd4;
    localparam logic [3:0] IDX_W2 = 4'd5;
    localparam logic [3:0] IDX_X3 = 4'd6;
    localparam logic [3:0] IDX_W3 = 4'd7;
    localparam logic [3:0] IDX_BIAS = 4'd8;
endpackage

// File: rtl/neuron_operand_loader_settle_timer.sv
// settle_timer: loadable 8-bit down-counter that stops at zero and flags done
module settle_timer (
    input  logic       clock,
    input  logic       reset,
    input  logic       load,
    input  logic [7:0] load_val,
    output logic       done
);
    logic [7:0] cnt;
    always_ff @(posedge clock) begin
        if (reset) cnt <= '0;
        else if (load) cnt <= load_val;
        else if (cnt != 8'd0) cnt <= cnt - 8'd1;
    end
    assign done = cnt == 8'd0;
endmodule

// File: rtl/neuron_operand_loader.sv
// neuron_operand_loader: assembles a streamed operand frame, holds it to settle, captures the neuron result
module neuron_operand_loader
    import neuron_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int RES_W = DEF_RES_W,
    parameter int SETTLE_CYCLES = 6
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              flush,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic [DATA_W-1:0] x0,
    output logic [DATA_W-1:0] x1,
    output logic [DATA_W-1:0] x2,
    output logic [DATA_W-1:0] x3,
    output logic [DATA_W-1:0] w0,
    output logic [DATA_W-1:0] w1,
    output logic [DATA_W-1:0] w2,
    output logic [DATA_W-1:0] w3,
    output logic [DATA_W-1:0] bias,
    input  logic [RES_W-1:0]  nu_sum,
    input  logic [RES_W-1:0]  nu_out,
    output logic [RES_W-1:0]  m_sum,
    output logic [RES_W-1:0]  m_out,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              busy,
    output logic [15:0]       frame_cnt
);
    state_t state, state_n;
    logic [3:0] idx;
    logic [WORDS_PER_FRAME-1:0][DATA_W-1:0] ops;
    logic take, last, xfer, done;
    assign take = s_valid && s_ready && !flush;
    assign last = take && idx == IDX_BIAS;
    assign xfer = m_valid && m_ready;
    settle_timer u_timer (
        .clock(clock),
        .reset(reset),
        .load(last),
        .load_val(8'(SETTLE_CYCLES - 1)),
        .done(done)
    );
    always_ff @(posedge clock) begin
        state <= reset ? LOAD : state_n;
    end
    always_comb begin
        state_n = (state == LOAD && last) ? SETTLE :
                  (state == SETTLE && done) ? PRESENT :
                  (state == PRESENT && xfer) ? LOAD : state;
    end
    always_comb begin
        s_ready = state == LOAD && !reset;
        busy = state != LOAD;
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            idx <= '0;
            ops <= '0;
            m_sum <= '0;
            m_out <= '0;
            m_valid <= 1'b0;
            frame_cnt <= '0;
        end else begin
            if (state == LOAD && flush) idx <= '0;
            else if (take) idx <= last ? 4'd0 : idx + 4'd1;
            if (take) ops[idx] <= s_data;
            if (state == SETTLE && done) begin
                m_sum <= nu_sum;
                m_out <= nu_out;
                m_valid <= 1'b1;
            end else if (xfer) m_valid <= 1'b0;
            if (xfer) frame_cnt <= frame_cnt + 16'd1;
        end
    end
    assign x0 = ops[IDX_X0];
    assign w0 = ops[IDX_W0];
    assign x1 = ops[IDX_X1];
    assign w1 = ops[IDX_W1];
    assign x2 = ops[IDX_X2];
    assign w2 = ops[IDX_W2];
    assign x3 = ops[IDX_X3];
    assign w3 = ops[IDX_W3];
    assign bias = ops[IDX_BIAS];
endmodule

// File: tb/tb_neuron_operand_loader.sv
// tb_neuron_operand_loader: directed checks of the loader against a behavioural neuron
module tb_neuron_operand_loader;
    logic clock = 1'b0;
    logic reset = 1'b1;
    logic flush = 1'b0;
    logic s_valid = 1'b0;
    logic m_ready = 1'b0;
    logic [15:0] s_data = '0;
    logic s_ready, m_valid, busy;
    logic [15:0] x0, x1, x2, x3, w0, w1, w2, w3, bias, frame_cnt;
    logic [31:0] nu_sum, nu_out, m_sum, m_out;
    int checks = 0;
    int failures = 0;
    int n;
    int seen;

    neuron_operand_loader #(.DATA_W(16), .RES_W(32), .SETTLE_CYCLES(6)) dut (
        .clock(clock), .reset(reset), .flush(flush),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .x0(x0), .x1(x1), .x2(x2), .x3(x3),
        .w0(w0), .w1(w1), .w2(w2), .w3(w3), .bias(bias),
        .nu_sum(nu_sum), .nu_out(nu_out),
        .m_sum(m_sum), .m_out(m_out), .m_valid(m_valid), .m_ready(m_ready),
        .busy(busy), .frame_cnt(frame_cnt)
    );

    assign nu_sum = 32'(int'(x0) * int'(w0) + int'(x1) * int'(w1) + int'(x2) * int'(w2)
                    + int'(x3) * int'(w3) + int'($signed(bias)));
    assign nu_out = $signed(nu_sum) < 0 ? 32'd0 : nu_sum;

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send(input logic [15:0] d);
        s_valid = 1'b1;
        s_data = d;
        tick();
        s_valid = 1'b0;
    endtask

    task automatic frame(input logic [15:0] a0, b0, a1, b1, a2, b2, a3, b3, bb);
        send(a0); send(b0); send(a1); send(b1);
        send(a2); send(b2); send(a3); send(b3); send(bb);
    endtask

    task automatic wait_valid(output int cnt);
        cnt = 0;
        while (!m_valid && cnt < 40) begin
            tick();
            cnt++;
        end
    endtask

    initial begin
        tick();
        tick();
        check("rst_s_ready", 32'(s_ready), 32'd0);
        check("rst_x0", 32'(x0), 32'd0);
        check("rst_bias", 32'(bias), 32'd0);
        check("rst_m_valid", 32'(m_valid), 32'd0);
        check("rst_m_sum", m_sum, 32'd0);
        check("rst_frame_cnt", 32'(frame_cnt), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        #1;
        check("rel_s_ready", 32'(s_ready), 32'd1);

        m_ready = 1'b1;
        frame(16'd1, 16'd2, 16'd2, 16'd3, 16'd3, 16'd4, 16'd4, 16'd5, 16'd50);
        check("basic_busy", 32'(busy), 32'd1);
        check("basic_s_ready", 32'(s_ready), 32'd0);
        check("basic_x3", 32'(x3), 32'd4);
        check("basic_w3", 32'(w3), 32'd5);
        check("basic_bias", 32'(bias), 32'd50);
        wait_valid(n);
        check("basic_latency", 32'(n), 32'd6);
        check("basic_m_sum", m_sum, 32'd90);
        check("basic_m_out", m_out, 32'd90);
        tick();
        check("basic_m_valid_clr", 32'(m_valid), 32'd0);
        check("basic_frame_cnt", 32'(frame_cnt), 32'd1);
        check("basic_s_ready_after", 32'(s_ready), 32'd1);

        m_ready = 1'b0;
        frame(16'd1, 16'd2, 16'd2, 16'd3, 16'd3, 16'd4, 16'd4, 16'd5, 16'hFFCE);
        check("neg_bias_port", 32'(bias), 32'h0000FFCE);
        wait_valid(n);
        check("neg_latency", 32'(n), 32'd6);
        check("neg_m_sum", m_sum, 32'hFFFFFFF6);
        check("neg_m_out", m_out, 32'd0);
        repeat (20) begin
            tick();
            check("hold_flags", {30'd0, m_valid, s_ready}, 32'd2);
            check("hold_m_sum", m_sum, 32'hFFFFFFF6);
            check("hold_m_out", m_out, 32'd0);
        end
        check("hold_frame_cnt", 32'(frame_cnt), 32'd1);
        m_ready = 1'b1;
        tick();
        check("bp_m_valid_clr", 32'(m_valid), 32'd0);
        check("bp_s_ready", 32'(s_ready), 32'd1);
        check("bp_frame_cnt", 32'(frame_cnt), 32'd2);

        send(16'd9); send(16'd9); send(16'd9); send(16'd9);
        s_valid = 1'b1;
        s_data = 16'd9;
        flush = 1'b1;
        tick();
        s_valid = 1'b0;
        flush = 1'b0;
        check("flush_drop_x2", 32'(x2), 32'd3);
        check("flush_keep_x0", 32'(x0), 32'd9);
        send(16'd7);
        check("flush_restart_x0", 32'(x0), 32'd7);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_keep_w0", 32'(w0), 32'd9);
        check("flush_idle_busy", 32'(busy), 32'd0);
        frame(16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd1, 16'd7, 16'd0);
        check("flush_frame_x3", 32'(x3), 32'd1);
        check("flush_frame_w3", 32'(w3), 32'd7);
        wait_valid(n);
        check("flush_latency", 32'(n), 32'd6);
        check("flush_m_sum", m_sum, 32'd7);
        check("flush_m_out", m_out, 32'd7);
        tick();
        check("flush_frame_cnt", 32'(frame_cnt), 32'd3);

        frame(16'd1, 16'd2, 16'd2, 16'd3, 16'd3, 16'd4, 16'd4, 16'd5, 16'd50);
        tick();
        tick();
        reset = 1'b1;
        tick();
        check("rs_m_valid", 32'(m_valid), 32'd0);
        check("rs_frame_cnt", 32'(frame_cnt), 32'd0);
        check("rs_x0", 32'(x0), 32'd0);
        check("rs_w3", 32'(w3), 32'd0);
        check("rs_bias", 32'(bias), 32'd0);
        check("rs_s_ready_in_reset", 32'(s_ready), 32'd0);
        reset = 1'b0;
        #1;
        check("rs_s_ready_release", 32'(s_ready), 32'd1);
        check("rs_busy", 32'(busy), 32'd0);
        seen = 0;
        repeat (10) begin
            tick();
            if (m_valid) seen++;
        end
        check("rs_no_result", 32'(seen), 32'd0);

        force dut.frame_cnt = 16'hFFFF;
        #1;
        release dut.frame_cnt;
        #1;
        check("wrap_preload", 32'(frame_cnt), 32'h0000FFFF);
        frame(16'd1, 16'd2, 16'd2, 16'd3, 16'd3, 16'd4, 16'd4, 16'd5, 16'd50);
        wait_valid(n);
        check("wrap_latency", 32'(n), 32'd6);
        tick();
        check("wrap_frame_cnt", 32'(frame_cnt), 32'd0);
        check("wrap_m_valid_clr", 32'(m_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=no_finish expected=finish");
        $fatal(1, "timeout");
    end
endmodule
